membrane_accumulator: RTL

//  Feeding end of spike_residue's 4-phase BD link: drives its L input, collects OutSpike/Residue.
//  Per timestep: sum NUM_PSUM partial sums onto stored residue, send potential on L,

---
 rtl/membrane_pkg.sv | 17 +
 rtl/membrane_accumulator_hs_sync.sv | 19 +
 rtl/membrane_accumulator.sv | 122 ++++++++++++
 3 files changed

// File: rtl/membrane_pkg.sv
// Shared types and arithmetic for the membrane accumulator.
package membrane_pkg;

  typedef enum logic [2:0] {
    ACC, ACC_RTZ, SEND_L, SEND_RTZ, RECV, FWD
  } state_t;

  // Unsigned add clamped to 2^w-1; the wide sum makes overflow visible before clamping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] s, mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    return (s > mx) ? mx[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/membrane_accumulator_hs_sync.sv
// Two-flop synchronizer for one asynchronous handshake wire.
module hs_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/membrane_accumulator.sv
// Accumulates partial sums onto the stored residue, ships the potential to spike_residue,
// collects spike + residue back and forwards the spike downstream. All links are 4-phase BD.
module membrane_accumulator
  import membrane_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_PSUM = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             psum_req,
  input  logic [WIDTH-1:0] psum_data,
  output logic             psum_ack,
  output logic             l_req,
  output logic [WIDTH-1:0] l_data,
  input  logic             l_ack,
  input  logic             res_req,
  input  logic [WIDTH-1:0] res_data,
  output logic             res_ack,
  input  logic             spk_req,
  input  logic             spk_data,
  output logic             spk_ack,
  output logic             out_req,
  output logic             out_data,
  input  logic             out_ack
);
  localparam int NSYNC = 5;
  localparam int CW    = $clog2(NUM_PSUM + 1);

  logic [NSYNC-1:0] async_in, sync_out;
  logic s_psum_req, s_l_ack, s_res_req, s_spk_req, s_out_ack;

  assign async_in = {out_ack, spk_req, res_req, l_ack, psum_req};
  assign {s_out_ack, s_spk_req, s_res_req, s_l_ack, s_psum_req} = sync_out;

  for (genvar g = 0; g < NSYNC; g++) begin : g_sync
    hs_sync u_sync (.clk(clk), .rst_n(rst_n), .d(async_in[g]), .q(sync_out[g]));
  end

  state_t           state;
  logic [WIDTH-1:0] acc, residue;
  logic [CW-1:0]    psum_cnt;
  logic             res_done, spk_done, out_done, spk_latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      residue   <= '0;
      psum_cnt  <= '0;
      psum_ack  <= 1'b0;
      l_req     <= 1'b0;
      l_data    <= '0;
      res_ack   <= 1'b0;
      spk_ack   <= 1'b0;
      out_req   <= 1'b0;
      out_data  <= 1'b0;
      res_done  <= 1'b0;
      spk_done  <= 1'b0;
      out_done  <= 1'b0;
      spk_latch <= 1'b0;
    end else begin
      case (state)
        ACC: if (s_psum_req) begin
          acc      <= WIDTH'(sat_add(32'(acc), 32'(psum_data), WIDTH));
          psum_ack <= 1'b1;
          psum_cnt <= psum_cnt + 1'b1;
          state    <= ACC_RTZ;
        end
        ACC_RTZ: if (!s_psum_req) begin
          psum_ack <= 1'b0;
          state    <= (psum_cnt == CW'(NUM_PSUM)) ? SEND_L : ACC;
        end
        SEND_L: begin
          // l_data is loaded only while l_req is low, so it is frozen for the whole request.
          if (!l_req) begin
            l_data <= acc;
            l_req  <= 1'b1;
          end else if (s_l_ack) begin
            l_req <= 1'b0;
            state <= SEND_RTZ;
          end
        end
        SEND_RTZ: if (!s_l_ack) state <= RECV;
        RECV: begin
          if (!res_done && !res_ack && s_res_req) begin
            residue <= res_data;
            res_ack <= 1'b1;
          end else if (res_ack && !s_res_req) begin
            res_ack  <= 1'b0;
            res_done <= 1'b1;
          end
          if (!spk_done && !spk_ack && s_spk_req) begin
            spk_latch <= spk_data;
            spk_ack   <= 1'b1;
          end else if (spk_ack && !s_spk_req) begin
            spk_ack  <= 1'b0;
            spk_done <= 1'b1;
          end
          if (res_done && spk_done) state <= FWD;
        end
        FWD: begin
          if (!out_req && !out_done) begin
            out_data <= spk_latch;
            out_req  <= 1'b1;
          end else if (out_req && s_out_ack) begin
            out_req  <= 1'b0;
            out_done <= 1'b1;
          end else if (out_done && !s_out_ack) begin
            acc      <= residue;
            psum_cnt <= '0;
            res_done <= 1'b0;
            spk_done <= 1'b0;
            out_done <= 1'b0;
            state    <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule
